// File: rtl/dither_expand.sv
// dither_expand: widens two packed narrow lanes to wide lanes through a valid/ready stage with a 1-entry skid buffer.
// Define DITHER_EN for LFSR dither refill of the discarded LSBs; otherwise they are refilled with the midpoint.
module dither_expand #(
    parameter int          WID_DATA_IN  = 8,
    parameter int          WID_DATA_OUT = 32,
    parameter int          WID_SHIFT    = WID_DATA_OUT - WID_DATA_IN,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*WID_DATA_IN-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*WID_DATA_OUT-1:0] out_data,
    input  logic                      lfsr_load
);
    if (WID_SHIFT != WID_DATA_OUT - WID_DATA_IN || WID_SHIFT < 1 || WID_SHIFT > 32)
        $error("dither_expand: WID_SHIFT must equal WID_DATA_OUT-WID_DATA_IN and lie in 1..32");
    if (LFSR_SEED == 32'h0)
        $error("dither_expand: LFSR_SEED must be nonzero");

    logic [WID_SHIFT-1:0]      fill0;
    logic [WID_SHIFT-1:0]      fill1;
    logic [2*WID_DATA_OUT-1:0] wide;
    logic [2*WID_DATA_OUT-1:0] skid_data;
    logic                      skid_full;
    logic                      accept;

    assign in_ready = ~skid_full;
    assign accept   = in_valid & in_ready;

`ifdef DITHER_EN
    logic [31:0] lfsr;

    // Reload beats advance; a beat accepted alongside a reload still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if (lfsr_load)
            lfsr <= LFSR_SEED;
        else if (accept)
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    end

    assign fill0 = lfsr[WID_SHIFT-1:0];
    assign fill1 = lfsr[31 -: WID_SHIFT];
`else
    localparam logic [WID_SHIFT-1:0] FILL_MID = WID_SHIFT'(64'd1 << (WID_SHIFT - 1));
    logic unused_load;

    assign unused_load = lfsr_load;
    assign fill0       = FILL_MID;
    assign fill1       = FILL_MID;
`endif

    assign wide = {in_data[2*WID_DATA_IN-1 -: WID_DATA_IN], fill1,
                   in_data[WID_DATA_IN-1:0], fill0};

    // Output register refills from the skid first so beat order is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_full) begin
                out_data  <= skid_data;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_data <= wide;
            end
            out_valid <= skid_full | accept;
        end else if (accept) begin
            skid_data <= wide;
            skid_full <= 1'b1;
        end
    end
endmodule
